// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit count, decade maximum, digit type and load sanitiser.
package bcd_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Non-decimal nibbles are forced to zero so a digit register never holds > 9.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with clear > load > step priority.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - synchronous zero
//   load        - synchronous load of load_val (non-BCD nibble loads as 0)
//   load_val    - nibble to load
//   cin         - step request from the lower decade (or the count enable)
//   up          - 1 = increment, 0 = decrement
//   digit       - registered decade value, always 0..9
//   cout_c      - combinational roll-over request to the next decade
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] digit,
  output logic       cout_c
);

  bcd_digit_t digit_nxt;

  // Next decade value.
  always_comb begin
    digit_nxt = digit;
    if (clear) begin
      digit_nxt = 4'd0;
    end else if (load) begin
      digit_nxt = bcd_sanitize(load_val);
    end else if (cin) begin
      if (up) begin
        digit_nxt = (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
      end else begin
        digit_nxt = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  // Roll-over only meaningful when no clear/load; the parent masks the final carry.
  always_comb begin
    cout_c = 1'b0;
    if (cin) begin
      cout_c = up ? (digit == BCD_MAX) : (digit == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else begin
      digit <= digit_nxt;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit up/down BCD counter with multiplexed 7-segment digit scan.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - synchronous zero of the count (highest priority)
//   load        - synchronous load of load_val
//   load_val    - four BCD nibbles, digit 3 in [15:12]
//   en, up      - one count step per en cycle, direction by up
//   count       - registered four-digit BCD value
//   carry       - one-cycle pulse on 9999->0000 or 0000->9999 wrap
//   bcd_out     - registered scanned digit
//   dig_sel     - registered one-hot digit select aligned with bcd_out
// Compile option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  input  logic        up,
  output logic [15:0] count,
  output logic        carry,
  output logic [3:0]  bcd_out,
  output logic [3:0]  dig_sel
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  bcd_digit_t         digs [DIGITS];
  logic [DIGITS:0]    chain;
  logic               carry_nxt;

  logic [PW-1:0]      presc;
  logic [PW-1:0]      presc_nxt;
  logic [1:0]         idx;
  logic [1:0]         idx_nxt;
  logic [DIGITS-1:0]  blank;
  logic [3:0]         bcd_nxt;
  logic [3:0]         sel_nxt;

  assign chain[0] = en;

  // Decade chain: each digit steps when all lower digits roll over.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[4*g +: 4]),
      .cin      (chain[g]),
      .up       (up),
      .digit    (digs[g]),
      .cout_c   (chain[g+1])
    );
  end

  assign count = {digs[3], digs[2], digs[1], digs[0]};

  // Wrap pulse only when the step actually happens.
  assign carry_nxt = chain[DIGITS] & ~clear & ~load;

  // Scan prescaler and digit index, independent of count controls.
  always_comb begin
    presc_nxt = presc + PW'(1);
    idx_nxt   = idx;
    if (presc == PW'(SCAN_DIV - 1)) begin
      presc_nxt = '0;
      idx_nxt   = idx + 2'd1;
    end
  end

  // Leading-zero mask: digit i blanked when it and every higher digit are zero.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (digs[i] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  // Scan output from the current count and index; registered below (1-cycle lag).
  always_comb begin
    bcd_nxt = digs[idx];
    sel_nxt = 4'd1 << idx;
    if (blank[idx]) begin
      bcd_nxt = 4'd0;
      sel_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry   <= 1'b0;
      presc   <= '0;
      idx     <= 2'd0;
      bcd_out <= 4'd0;
      dig_sel <= 4'b0001;
    end else begin
      carry   <= carry_nxt;
      presc   <= presc_nxt;
      idx     <= idx_nxt;
      bcd_out <= bcd_nxt;
      dig_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (SCAN_DIV = 4).
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_scan_counter #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .count    (count),
    .carry    (carry),
    .bcd_out  (bcd_out),
    .dig_sel  (dig_sel)
  );

  typedef struct packed {
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] exp_count;
    logic        exp_carry;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  logic [16:0] cnt_q [$];
  logic [7:0]  scan_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic l, input logic [15:0] lv,
                              input logic e, input logic u, input logic [15:0] ec,
                              input logic ecy);
    vec_t v;
    v.clear = c; v.load = l; v.load_val = lv; v.en = e; v.up = u;
    v.exp_count = ec; v.exp_carry = ecy;
    return v;
  endfunction

  function automatic bit blanked(input logic [15:0] v, input int i);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] t;
    if (i == 0) return 1'b0;
    t = v >> (4 * i);
    return (t == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Reset, load value on the first edge, then check 16 scan cycles.
  task automatic scan_run(input logic [15:0] value);
    logic [16:0] dummy;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1; load = 1'b1; load_val = value;
    @(posedge clk); #1;
    chk("scan_lag_bcd", 32'(bcd_out), 32'h0);
    chk("scan_lag_sel", 32'(dig_sel), 32'h1);
    chk("scan_load", 32'(count), 32'(value));
    @(negedge clk);
    load = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      int i;
      logic [3:0] eb;
      logic [3:0] es;
      i  = ((k - 1) / 4) % 4;
      eb = value[4*i +: 4];
      es = 4'(1 << i);
      if (blanked(value, i)) begin
        eb = 4'h0;
        es = 4'h0;
      end
      scan_q.push_back({eb, es});
      if (k == 2) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      dummy = 17'(scan_q[0]);
      chk($sformatf("scan_%h_k%0d_bcd", value, k), 32'(bcd_out), 32'(scan_q[0][7:4]));
      chk($sformatf("scan_%h_k%0d_sel", value, k), 32'(dig_sel), 32'(scan_q[0][3:0]));
      void'(scan_q.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 16'h0998, 0, 1, 16'h0998, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 1, 16'h0999, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 1, 1, 16'h1000, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 1, 1, 16'h1001, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 1, 16'h1001, 0);
    vecs[5]  = mk(0, 1, 16'h9999, 0, 1, 16'h9999, 0);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 1);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 0, 16'h9999, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 1, 0, 16'h9998, 0);
    vecs[10] = mk(0, 1, 16'h1A3F, 0, 1, 16'h1030, 0);
    vecs[11] = mk(1, 1, 16'h4321, 1, 1, 16'h0000, 0);
    vecs[12] = mk(0, 1, 16'h5555, 1, 1, 16'h5555, 0);
    vecs[13] = mk(0, 0, 16'h0000, 1, 0, 16'h5554, 0);
    vecs[14] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0);
    vecs[15] = mk(0, 1, 16'h0109, 1, 1, 16'h0109, 0);
    vecs[16] = mk(0, 0, 16'h0000, 1, 1, 16'h0110, 0);
    vecs[17] = mk(0, 1, 16'hFFFF, 0, 1, 16'h0000, 0);
    vecs[18] = mk(0, 1, 16'h9999, 1, 1, 16'h9999, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_sel", 32'(dig_sel), 32'h1);

    @(negedge clk);
    rst_n = 1'b1;

    // Count/control vectors through the scoreboard.
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      clear = vecs[v].clear; load = vecs[v].load; load_val = vecs[v].load_val;
      en = vecs[v].en; up = vecs[v].up;
      cnt_q.push_back({vecs[v].exp_count, vecs[v].exp_carry});
      @(posedge clk); #1;
      if (cnt_q.size() == 0) begin
        chk("sb_empty", 32'h1, 32'h0);
      end else begin
        chk($sformatf("vec%0d_count", v), 32'(count), 32'(cnt_q[0][16:1]));
        chk($sformatf("vec%0d_carry", v), 32'(carry), 32'(cnt_q[0][0]));
        void'(cnt_q.pop_front());
      end
    end
    @(negedge clk);
    clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;

    // Carry after a wrap lasts exactly one cycle even with en held.
    @(negedge clk); load = 1'b1; load_val = 16'h9998;
    @(negedge clk); load = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    chk("hold_en_9999", 32'({count, carry}), 32'({16'h9999, 1'b0}));
    @(posedge clk); #1;
    chk("hold_en_wrap", 32'({count, carry}), 32'({16'h0000, 1'b1}));
    @(posedge clk); #1;
    chk("hold_en_0001", 32'({count, carry}), 32'({16'h0001, 1'b0}));
    @(negedge clk); en = 1'b0;

    // Digit scan.
    scan_run(16'h1234);
    scan_run(16'h0007);
    scan_run(16'h0500);

    // Asynchronous reset mid-scan.
    @(negedge clk); load = 1'b1; load_val = 16'h5678;
    @(negedge clk); load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_carry", 32'(carry), 32'h0);
    chk("arst_bcd", 32'(bcd_out), 32'h0);
    chk("arst_sel", 32'(dig_sel), 32'h1);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", 32'(count), 32'h0);
    chk("post_rst_sel", 32'(dig_sel), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
